// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing the 8-bit data memory port.
// Reads wait RD_LAT cycles for memory data; writes and illegal commands finish right after issue.
module dmem_arbiter #(
    parameter int         RD_LAT   = 1,
    parameter logic [7:0] CMD_IDLE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic [7:0] mem_cmd,
    output logic [7:0] mem_addr,
    inout  wire  [7:0] mem_data
);
    localparam logic [7:0] CMD_RD = 8'h00;
    localparam logic [7:0] CMD_WR = 8'h01;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic       last, win, sel, any_req;
    logic [7:0] cmd_l, addr_l, wdata_l;
    logic [3:0] cnt;
    logic       is_rd, is_wr, drive;

    assign any_req = req0 | req1;
    // On contention the port that did not win last time gets the grant.
    assign sel     = (req0 & req1) ? ~last : req1;
    assign is_rd   = (cmd_l == CMD_RD);
    assign is_wr   = (cmd_l == CMD_WR);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = is_rd ? WAIT : DONE;
            WAIT:    if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
            win  <= 1'b0;
            cnt  <= 4'd0;
        end else begin
            if (state == IDLE && any_req) begin
                last <= sel;
                win  <= sel;
            end
            if (state == ISSUE)     cnt <= 4'(RD_LAT);
            else if (state == WAIT) cnt <= cnt - 4'd1;
        end
    end

    // Request payload needs no reset: it is only consumed after a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            cmd_l   <= sel ? cmd1   : cmd0;
            addr_l  <= sel ? addr1  : addr0;
            wdata_l <= sel ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0 <= 8'h00;
            rdata1 <= 8'h00;
        end else if (state == WAIT && cnt == 4'd1) begin
            if (win) rdata1 <= mem_data;
            else     rdata0 <= mem_data;
        end
    end

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        busy     = (state != IDLE);
        mem_cmd  = CMD_IDLE;
        mem_addr = 8'h00;
        drive    = 1'b0;
        case (state)
            ISSUE: begin
                gnt0 = ~win;
                gnt1 = win;
                if (is_rd || is_wr) begin
                    mem_cmd  = is_rd ? CMD_RD : CMD_WR;
                    mem_addr = addr_l;
                end
                drive = is_wr;
            end
            WAIT: begin
                mem_cmd  = CMD_RD;
                mem_addr = addr_l;
            end
            DONE: begin
                done0 = ~win;
                done1 = win;
            end
            default: ;
        endcase
    end

    assign mem_data = drive ? wdata_l : 8'bz;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two instances (RD_LAT 1 and 3), each with a bus-attached
// memory, checked against a transaction-level model of arbitration, timing and read data.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      req0_r, req1_r;
    logic [1:0][7:0] cmd0_r, cmd1_r, addr0_r, addr1_r, wdata0_r, wdata1_r;
    wire  [1:0]      gnt0_w, gnt1_w, done0_w, done1_w, busy_w;
    wire  [1:0][7:0] rdata0_w, rdata1_w, mcmd_w, maddr_w, mdat;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [2][256];
    logic [7:0] exp_rd  [2][2];
    int         last_m  [2];
    bit         pend    [2][2];
    logic [7:0] pc [2][2];
    logic [7:0] pa [2][2];
    logic [7:0] pw [2][2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire  [7:0] md;
        logic [7:0] mem [256];

        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ 8'h5A;
            end else if (mcmd_w[g] == 8'h01) begin
                mem[maddr_w[g]] <= md;
            end
        end
        assign md      = (mcmd_w[g] == 8'h00) ? mem[maddr_w[g]] : 8'bz;
        assign mdat[g] = md;

        dmem_arbiter #(.RD_LAT(g == 0 ? 1 : 3), .CMD_IDLE(8'hFF)) u_dut (
            .clk(clk), .rst(rst),
            .req0(req0_r[g]), .req1(req1_r[g]),
            .cmd0(cmd0_r[g]), .cmd1(cmd1_r[g]),
            .addr0(addr0_r[g]), .addr1(addr1_r[g]),
            .wdata0(wdata0_r[g]), .wdata1(wdata1_r[g]),
            .gnt0(gnt0_w[g]), .gnt1(gnt1_w[g]),
            .done0(done0_w[g]), .done1(done1_w[g]),
            .rdata0(rdata0_w[g]), .rdata1(rdata1_w[g]),
            .busy(busy_w[g]),
            .mem_cmd(mcmd_w[g]), .mem_addr(maddr_w[g]),
            .mem_data(md)
        );
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] b8(input logic x);
        return {7'b0, x};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] gnt_of(input int i, input int p);
        return b8(p ? gnt1_w[i] : gnt0_w[i]);
    endfunction

    function automatic logic [7:0] done_of(input int i, input int p);
        return b8(p ? done1_w[i] : done0_w[i]);
    endfunction

    function automatic logic [7:0] rdata_of(input int i, input int p);
        return p ? rdata1_w[i] : rdata0_w[i];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) ref_mem[i][k] = 8'(k) ^ 8'h5A;
            last_m[i] = 1;
            for (int p = 0; p < 2; p++) begin
                exp_rd[i][p] = 8'h00;
                pend[i][p]   = 1'b0;
            end
        end
    endtask

    task automatic drive_ports(input int i);
        req0_r[i] = pend[i][0]; cmd0_r[i] = pc[i][0]; addr0_r[i] = pa[i][0]; wdata0_r[i] = pw[i][0];
        req1_r[i] = pend[i][1]; cmd1_r[i] = pc[i][1]; addr1_r[i] = pa[i][1]; wdata1_r[i] = pw[i][1];
    endtask

    task automatic set_req(input int i, input int p, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] w);
        pend[i][p] = 1'b1; pc[i][p] = c; pa[i][p] = a; pw[i][p] = w;
    endtask

    task automatic rand_req(input int i, input int p);
        int k;
        logic [7:0] c;
        k = $urandom_range(0, 4);
        c = (k < 2) ? 8'h00 : (k < 4) ? 8'h01 : 8'($urandom_range(2, 255));
        set_req(i, p, c, 8'($urandom_range(0, 15)), 8'($urandom));
    endtask

    task automatic idle_checks(input int i);
        check("idle_busy", b8(busy_w[i]), 8'h00);
        check("idle_cmd", mcmd_w[i], 8'hFF);
        check("idle_addr", maddr_w[i], 8'h00);
        check("idle_mdata", mdat[i], 8'bz);
        check("idle_gnt", {6'b0, gnt1_w[i], gnt0_w[i]}, 8'h00);
        check("idle_done", {6'b0, done1_w[i], done0_w[i]}, 8'h00);
        check("idle_rdata0", rdata0_w[i], exp_rd[i][0]);
        check("idle_rdata1", rdata1_w[i], exp_rd[i][1]);
    endtask

    // One complete transaction from the pending requests, starting in IDLE.
    task automatic serve(input int i);
        int w, o;
        logic [7:0] c, a, d, ecmd;
        @(negedge clk);
        drive_ports(i);
        if (pend[i][0] && pend[i][1]) w = (last_m[i] == 0) ? 1 : 0;
        else                          w = pend[i][0] ? 0 : 1;
        o = 1 - w;
        c = pc[i][w]; a = pa[i][w]; d = pw[i][w];
        last_m[i] = w;
        ecmd = (c == 8'h00) ? 8'h00 : (c == 8'h01) ? 8'h01 : 8'hFF;

        @(negedge clk);
        check("gnt_win", gnt_of(i, w), 8'h01);
        check("gnt_lose", gnt_of(i, o), 8'h00);
        check("busy_issue", b8(busy_w[i]), 8'h01);
        check("issue_cmd", mcmd_w[i], ecmd);
        if (ecmd != 8'hFF) check("issue_addr", maddr_w[i], a);
        if (ecmd == 8'h01) check("issue_wdata", mdat[i], d);
        if (ecmd == 8'hFF) check("issue_mdata_z", mdat[i], 8'bz);
        pend[i][w] = 1'b0;
        drive_ports(i);

        if (ecmd == 8'h00) begin
            for (int k = 0; k < lat_of(i); k++) begin
                @(negedge clk);
                check("wait_cmd", mcmd_w[i], 8'h00);
                check("wait_addr", maddr_w[i], a);
                check("wait_done", done_of(i, w), 8'h00);
            end
        end

        @(negedge clk);
        if (ecmd == 8'h00) exp_rd[i][w] = ref_mem[i][a];
        if (ecmd == 8'h01) ref_mem[i][a] = d;
        check("done_win", done_of(i, w), 8'h01);
        check("done_lose", done_of(i, o), 8'h00);
        check("done_gnt", {6'b0, gnt1_w[i], gnt0_w[i]}, 8'h00);
        check("done_cmd", mcmd_w[i], 8'hFF);
        check("done_mdata_z", mdat[i], 8'bz);
        check("rdata_win", rdata_of(i, w), exp_rd[i][w]);
        check("rdata_lose", rdata_of(i, o), exp_rd[i][o]);
    endtask

    initial begin
        rst = 1'b1;
        reset_model();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                pc[i][p] = 8'h00; pa[i][p] = 8'h00; pw[i][p] = 8'h00;
            end
            drive_ports(i);
        end
        repeat (3) @(negedge clk);
        idle_checks(0);
        idle_checks(1);
        rst = 1'b0;

        // RD_LAT=1: write then read-back across ports, then an illegal command.
        set_req(0, 1, 8'h01, 8'h20, 8'hA5);
        serve(0);
        set_req(0, 0, 8'h00, 8'h20, 8'h00);
        serve(0);
        check("rdback_a5", rdata0_w[0], 8'hA5);
        set_req(0, 0, 8'h07, 8'h20, 8'h11);
        serve(0);

        // Both ports asserting continuously must alternate.
        set_req(0, 0, 8'h01, 8'h40, 8'h01);
        set_req(0, 1, 8'h01, 8'h41, 8'h02);
        for (int k = 0; k < 4; k++) begin
            serve(0);
            for (int p = 0; p < 2; p++)
                if (!pend[0][p]) set_req(0, p, 8'h01, 8'(8'h40 + k), 8'(k));
        end
        pend[0][0] = 1'b0; pend[0][1] = 1'b0;
        @(negedge clk); drive_ports(0);

        // RD_LAT=3 read of 8'h3C written by the other port.
        set_req(1, 1, 8'h01, 8'h30, 8'h3C);
        serve(1);
        set_req(1, 0, 8'h00, 8'h30, 8'h00);
        serve(1);
        check("rdback_3c", rdata0_w[1], 8'h3C);

        // Reset in the middle of a read aborts it without a done pulse.
        set_req(1, 0, 8'h00, 8'h31, 8'h00);
        @(negedge clk); drive_ports(1);
        @(negedge clk);
        check("abort_gnt", b8(gnt0_w[1]), 8'h01);
        pend[1][0] = 1'b0; drive_ports(1);
        @(negedge clk);
        check("abort_wait", mcmd_w[1], 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        idle_checks(1);
        @(negedge clk);
        check("abort_nodone", {6'b0, done1_w[1], done0_w[1]}, 8'h00);
        check("abort_busy", b8(busy_w[1]), 8'h00);

        // Randomized traffic on both latencies.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 40; n++) begin
                for (int p = 0; p < 2; p++)
                    if (!pend[i][p] && $urandom_range(0, 1) == 1) rand_req(i, p);
                if (!pend[i][0] && !pend[i][1]) rand_req(i, $urandom_range(0, 1));
                serve(i);
            end
            while (pend[i][0] || pend[i][1]) serve(i);
            @(negedge clk); drive_ports(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d want=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
